// File: rtl/boton_contador.sv
// Debounced push-button up/down counter: synchronizer, debounce FSM, 4-bit modulo-16 count.
// Define BOTON_AUTOREPEAT_EN to add auto-repeat pulses while the button is held.
module boton_contador #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button_raw,
  input  logic       up_down,
  output logic [3:0] count,
  output logic       pulse,
  output logic       pressed
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  localparam logic [19:0] TimerLast = 20'(DEBOUNCE_CYCLES - 1);

  state_t      state;
  logic        sync1;
  logic        btn_s;
  logic        accept;
  logic [19:0] timer;

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 1048575 || REPEAT_CYCLES < 2) begin : g_bad_params
    $error("boton_contador: DEBOUNCE_CYCLES or REPEAT_CYCLES out of range");
  end

`ifdef BOTON_AUTOREPEAT_EN
  localparam int RepW = $clog2(REPEAT_CYCLES);
  localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_CYCLES - 1);
  logic [RepW-1:0] rep_timer;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= button_raw;
      btn_s <= sync1;
    end
  end

  // Outputs trail the FSM by one register stage, so press and release latency stay symmetric.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      timer   <= '0;
      accept  <= 1'b0;
      pulse   <= 1'b0;
      count   <= 4'h0;
      pressed <= 1'b0;
`ifdef BOTON_AUTOREPEAT_EN
      rep_timer <= '0;
`endif
    end else begin
      accept  <= 1'b0;
      pulse   <= accept;
      pressed <= (state == PRESSED) || (state == RELEASE_WAIT);
      if (accept) begin
        count <= up_down ? count + 4'd1 : count - 4'd1;
      end
      case (state)
        IDLE: begin
          timer <= '0;
`ifdef BOTON_AUTOREPEAT_EN
          rep_timer <= '0;
`endif
          if (btn_s) begin
            state <= PRESS_WAIT;
            timer <= 20'd1;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state <= IDLE;
            timer <= '0;
          end else if (timer == TimerLast) begin
            state  <= PRESSED;
            timer  <= '0;
            accept <= 1'b1;
`ifdef BOTON_AUTOREPEAT_EN
            rep_timer <= '0;
`endif
          end else begin
            timer <= timer + 20'd1;
          end
        end
        PRESSED: begin
          if (!btn_s) begin
            state <= RELEASE_WAIT;
            timer <= 20'd1;
          end
`ifdef BOTON_AUTOREPEAT_EN
          // Release bounces resume the frozen repeat timer instead of restarting it.
          else if (rep_timer == RepLast) begin
            accept    <= 1'b1;
            rep_timer <= '0;
          end else begin
            rep_timer <= rep_timer + 1'b1;
          end
`endif
        end
        RELEASE_WAIT: begin
          if (btn_s) begin
            state <= PRESSED;
            timer <= '0;
          end else if (timer == TimerLast) begin
            state <= IDLE;
            timer <= '0;
          end else begin
            timer <= timer + 20'd1;
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boton_contador.sv
// Self-checking bench for boton_contador: scoreboard of expected counts popped on each pulse.
// Honors BOTON_AUTOREPEAT_EN to pick the expected auto-repeat behaviour.
module tb_boton_contador;

  logic       clk;
  logic       reset;
  logic       button_raw;
  logic       up_down;
  logic [3:0] count;
  logic       pulse;
  logic       pressed;

  int passed = 0;
  int total  = 0;

  logic [3:0] sb[$];
  logic [3:0] model_count;
  logic       prev_pulse;

  boton_contador #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .button_raw(button_raw),
    .up_down(up_down),
    .count(count),
    .pulse(pulse),
    .pressed(pressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not finish, passed=%0d total=%0d", passed, total);
    $fatal(1, "[TB] timeout");
  end

  // Every pulse consumes one scoreboard entry; pulses never come back to back.
  initial prev_pulse = 1'b0;
  always @(negedge clk) begin
    if (pulse === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        $display("[TB] FAIL unexpected_pulse: got pulse with count=%h, none expected", count);
      end else begin
        logic [3:0] exp_count;
        exp_count = sb.pop_front();
        if (count !== exp_count)
          $display("[TB] FAIL pulse_count: count=%h expected=%h", count, exp_count);
        else
          passed++;
      end
      total++;
      if (prev_pulse === 1'b1)
        $display("[TB] FAIL pulse_width: pulse high two cycles, actual=1 expected=0");
      else
        passed++;
    end
    prev_pulse = pulse;
  end

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset       = 1'b1;
    model_count = 4'h0;
    sb.delete();
  endtask

  task automatic press_release(input logic dir);
    up_down     = dir;
    model_count = dir ? model_count + 4'd1 : model_count - 4'd1;
    sb.push_back(model_count);
    button_raw = 1'b1;
    repeat (10) @(negedge clk);
    button_raw = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    button_raw = 1'b0;
    up_down    = 1'b1;
    reset      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (count !== 4'h0) $display("[TB] FAIL reset_count: count=%h expected=0", count);
    else passed++;
    total++;
    if (pulse !== 1'b0) $display("[TB] FAIL reset_pulse: pulse=%b expected=0", pulse);
    else passed++;
    total++;
    if (pressed !== 1'b0) $display("[TB] FAIL reset_pressed: pressed=%b expected=0", pressed);
    else passed++;
    reset       = 1'b1;
    model_count = 4'h0;
    sb.delete();
    @(negedge clk);
  endtask

  task automatic test_clean_press();
    up_down     = 1'b1;
    model_count = 4'h1;
    sb.push_back(model_count);
    button_raw = 1'b1;
    for (int e = 0; e <= 8; e++) begin
      @(posedge clk);
      #1;
      total++;
      if (pulse !== (e == 6))
        $display("[TB] FAIL press_timing: edge %0d pulse=%b expected=%b", e, pulse, (e == 6));
      else
        passed++;
    end
    total++;
    if (count !== 4'h1) $display("[TB] FAIL press_count: count=%h expected=1", count);
    else passed++;
    total++;
    if (pressed !== 1'b1) $display("[TB] FAIL press_pressed: pressed=%b expected=1", pressed);
    else passed++;
    @(negedge clk);
    button_raw = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (pressed !== 1'b0) $display("[TB] FAIL release_pressed: pressed=%b expected=0", pressed);
    else passed++;
    total++;
    if (sb.size() != 0) $display("[TB] FAIL press_sb: %0d pulses missing, expected 0", sb.size());
    else passed++;
  endtask

  task automatic test_bounce();
    for (int seg = 0; seg < 4; seg++) begin
      button_raw = (seg % 2 == 0);
      repeat (2) @(negedge clk);
    end
    button_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (pressed !== 1'b0) $display("[TB] FAIL bounce_pressed: cycle %0d pressed=%b expected=0", i, pressed);
      else passed++;
    end
    total++;
    if (count !== model_count) $display("[TB] FAIL bounce_count: count=%h expected=%h", count, model_count);
    else passed++;
    up_down     = 1'b1;
    model_count = model_count + 4'd1;
    sb.push_back(model_count);
    button_raw = 1'b1;
    repeat (10) @(negedge clk);
    button_raw = 1'b0;
    repeat (2) @(negedge clk);
    button_raw = 1'b1;
    repeat (10) @(negedge clk);
    button_raw = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (count !== model_count) $display("[TB] FAIL release_bounce_count: count=%h expected=%h", count, model_count);
    else passed++;
    total++;
    if (sb.size() != 0) $display("[TB] FAIL bounce_sb: %0d pulses missing, expected 0", sb.size());
    else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int p = 0; p < 16; p++) press_release(1'b1);
    total++;
    if (count !== 4'h0) $display("[TB] FAIL wrap_up: count=%h expected=0", count);
    else passed++;
    press_release(1'b0);
    total++;
    if (count !== 4'hF) $display("[TB] FAIL wrap_down: count=%h expected=f", count);
    else passed++;
    total++;
    if (sb.size() != 0) $display("[TB] FAIL wrap_sb: %0d pulses missing, expected 0", sb.size());
    else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int p = 0; p < 5; p++) press_release(1'b1);
    total++;
    if (count !== 4'h5) $display("[TB] FAIL mid_setup: count=%h expected=5", count);
    else passed++;
    up_down    = 1'b1;
    button_raw = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (count !== 4'h0) $display("[TB] FAIL mid_reset_count: count=%h expected=0", count);
    else passed++;
    total++;
    if (pressed !== 1'b0) $display("[TB] FAIL mid_reset_pressed: pressed=%b expected=0", pressed);
    else passed++;
    reset       = 1'b1;
    model_count = 4'h1;
    sb.push_back(model_count);
    repeat (12) @(negedge clk);
    total++;
    if (count !== 4'h1) $display("[TB] FAIL mid_repress_count: count=%h expected=1", count);
    else passed++;
    button_raw = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (sb.size() != 0) $display("[TB] FAIL mid_sb: %0d pulses missing, expected 0", sb.size());
    else passed++;
  endtask

  task automatic test_autorepeat();
    do_reset();
    up_down = 1'b1;
`ifdef BOTON_AUTOREPEAT_EN
    for (int k = 1; k <= 5; k++) sb.push_back(4'(k));
    model_count = 4'h5;
`else
    sb.push_back(4'h1);
    model_count = 4'h1;
`endif
    // First pulse lands after edge 6, repeats every 10 edges; release before the sixth.
    button_raw = 1'b1;
    repeat (52) @(negedge clk);
    button_raw = 1'b0;
    repeat (15) @(negedge clk);
    total++;
    if (count !== model_count) $display("[TB] FAIL autorepeat_count: count=%h expected=%h", count, model_count);
    else passed++;
    total++;
    if (sb.size() != 0) $display("[TB] FAIL autorepeat_sb: %0d pulses missing, expected 0", sb.size());
    else passed++;
  endtask

  initial begin
    reset       = 1'b0;
    button_raw  = 1'b0;
    up_down     = 1'b1;
    model_count = 4'h0;
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_wrap();
    test_reset_mid();
    test_autorepeat();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
